// File: rtl/apx_mul_arbiter.sv
// Round-robin arbiter sharing one approximate float multiplier among NUM_REQ requesters.
// One operation in flight: grant, send a, send b, collect z, hand result back.
module apx_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_z,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [31:0]             mul_a,
  output logic                    mul_a_stb,
  input  logic                    mul_a_ack,
  output logic [31:0]             mul_b,
  output logic                    mul_b_stb,
  input  logic                    mul_b_ack,
  input  logic [31:0]             mul_z,
  input  logic                    mul_z_stb,
  output logic                    mul_z_ack,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND_A = 3'd1;
  localparam logic [2:0] S_SEND_B = 3'd2;
  localparam logic [2:0] S_WAIT_Z = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]       state_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [31:0]      a_arr [NUM_REQ];
  logic [31:0]      b_arr [NUM_REQ];
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   probe;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
    end
  endgenerate

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    probe      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
      if (probe >= (IDX_W+1)'(NUM_REQ))
        probe = probe - (IDX_W+1)'(NUM_REQ);
      if (!pick_found && req_valid[probe[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = probe[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      rr_ptr_reg <= '0;
      grant_idx  <= '0;
      req_ack    <= '0;
      resp_valid <= '0;
      resp_z     <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_a_stb  <= 1'b0;
      mul_b_stb  <= 1'b0;
      mul_z_ack  <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      req_ack <= '0;
      case (state_reg)
        S_IDLE: begin
          if (pick_found) begin
            mul_a     <= a_arr[pick_idx];
            mul_b     <= b_arr[pick_idx];
            grant_idx <= pick_idx;
            req_ack   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            mul_a_stb <= 1'b1;
            busy      <= 1'b1;
            state_reg <= S_SEND_A;
          end
        end
        S_SEND_A: begin
          if (mul_a_stb && mul_a_ack) begin
            mul_a_stb <= 1'b0;
            mul_b_stb <= 1'b1;
            state_reg <= S_SEND_B;
          end
        end
        S_SEND_B: begin
          if (mul_b_stb && mul_b_ack) begin
            mul_b_stb <= 1'b0;
            mul_z_ack <= 1'b1;
            state_reg <= S_WAIT_Z;
          end
        end
        S_WAIT_Z: begin
          if (mul_z_stb && mul_z_ack) begin
            mul_z_ack  <= 1'b0;
            resp_z     <= mul_z;
            resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
            state_reg  <= S_RESP;
          end
        end
        S_RESP: begin
          // Only the granted requester's ready can release the result.
          if (resp_ready[grant_idx]) begin
            resp_valid <= '0;
            op_count   <= op_count + CNT_W'(1);
            rr_ptr_reg <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
            busy       <= 1'b0;
            state_reg  <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apx_mul_arbiter.sv
// Scoreboarded bench for apx_mul_arbiter with a handshaking multiplier model.
module tb_apx_mul_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 3;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_z;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [31:0]           mul_a;
  logic                  mul_a_stb;
  logic                  mul_a_ack;
  logic [31:0]           mul_b;
  logic                  mul_b_stb;
  logic                  mul_b_ack;
  logic [31:0]           mul_z;
  logic                  mul_z_stb;
  logic                  mul_z_ack;
  logic [IDX_W-1:0]      grant_idx;
  logic                  busy;
  logic [CNT_W-1:0]      op_count;

  apx_mul_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ack(req_ack),
    .resp_valid(resp_valid), .resp_z(resp_z), .resp_ready(resp_ready),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .grant_idx(grant_idx), .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester i operands and hand-computed products:
  // 1.0*2.0=2.0, 2.0*2.0=4.0, 3.0*1.5=4.5, 1.5*1.5=2.25
  logic [31:0] tab_a [4];
  logic [31:0] tab_b [4];
  logic [31:0] tab_z [4];

  int tests = 0;
  int fails = 0;
  int exp_ack_q [$];
  int exp_rid_q [$];
  logic [31:0] exp_z_q [$];
  logic hold_z = 1'b0;
  logic mock_flush = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_op(input int r);
    exp_ack_q.push_back(r);
    exp_rid_q.push_back(r);
    exp_z_q.push_back(tab_z[r]);
  endtask

  // Multiplier model: normal operands only, truncated mantissa.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [7:0]  e;
    logic [22:0] m;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (p[47]) begin
      m = p[46:24];
      e = a[30:23] + b[30:23] - 8'd126;
    end else begin
      m = p[45:23];
      e = a[30:23] + b[30:23] - 8'd127;
    end
    return {a[31] ^ b[31], e, m};
  endfunction

  initial begin
    logic [31:0] cap_a;
    logic [31:0] cap_b;
    mul_a_ack = 1'b0;
    mul_b_ack = 1'b0;
    mul_z_stb = 1'b0;
    mul_z     = '0;
    forever begin
      @(negedge clk);
      while (!mul_a_stb) @(negedge clk);
      cap_a = mul_a;
      mul_a_ack = 1'b1;
      @(negedge clk);
      mul_a_ack = 1'b0;
      while (!mul_b_stb) @(negedge clk);
      cap_b = mul_b;
      mul_b_ack = 1'b1;
      @(negedge clk);
      mul_b_ack = 1'b0;
      repeat (2) @(negedge clk);
      while (hold_z) @(negedge clk);
      if (mock_flush) begin
        mock_flush = 1'b0;
      end else begin
        mul_z = fmul(cap_a, cap_b);
        mul_z_stb = 1'b1;
        while (!mul_z_ack) @(negedge clk);
        @(negedge clk);
        mul_z_stb = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each new ack pulse and each new response.
  initial begin
    logic [NUM_REQ-1:0] prev_ack;
    logic [NUM_REQ-1:0] prev_rv;
    int r;
    prev_ack = '0;
    prev_rv  = '0;
    forever begin
      @(negedge clk);
      if (req_ack != 0) begin
        if (prev_ack != 0) begin
          check("ack_pulse_width", 32'(req_ack), 32'd0);
        end else if (exp_ack_q.size() == 0) begin
          check("ack_unexpected", 32'(req_ack), 32'd0);
        end else begin
          r = exp_ack_q.pop_front();
          check("req_ack", 32'(req_ack), 32'd1 << r);
          $display("[TB] grant req%0d", r);
        end
      end
      if (resp_valid != 0 && prev_rv == 0) begin
        if (exp_rid_q.size() == 0) begin
          check("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          r = exp_rid_q.pop_front();
          check("resp_valid", 32'(resp_valid), 32'd1 << r);
          check("resp_z", resp_z, exp_z_q.pop_front());
          $display("[TB] resp req%0d z=0x%08h", r, resp_z);
        end
      end
      prev_ack = req_ack;
      prev_rv  = resp_valid;
    end
  end

  task automatic run_reqs(input logic [3:0] mask);
    int cyc;
    req_valid = mask;
    cyc = 0;
    while ((req_valid != 0 || busy) && cyc < 400) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ack;
      cyc++;
    end
    check("run_timeout", 32'(cyc < 400), 32'd1);
    req_valid = '0;
  endtask

  initial begin
    int cyc;
    int acks;
    logic [31:0] held_z;
    tab_a[0] = 32'h3F800000; tab_b[0] = 32'h40000000; tab_z[0] = 32'h40000000;
    tab_a[1] = 32'h40000000; tab_b[1] = 32'h40000000; tab_z[1] = 32'h40800000;
    tab_a[2] = 32'h40400000; tab_b[2] = 32'h3FC00000; tab_z[2] = 32'h40900000;
    tab_a[3] = 32'h3FC00000; tab_b[3] = 32'h3FC00000; tab_z[3] = 32'h40100000;
    req_a = {tab_a[3], tab_a[2], tab_a[1], tab_a[0]};
    req_b = {tab_b[3], tab_b[2], tab_b[1], tab_b[0]};
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_stb_ack", 32'({mul_a_stb, mul_b_stb, mul_z_ack}), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_grant_idx", 32'(grant_idx), 32'd0);
    check("rst_resp_z", resp_z, 32'd0);
    check("rst_mul_ab", mul_a | mul_b, 32'd0);
    rst = 1'b0;

    // Single request, then requester 2, then 0 and 3 together (rr_ptr now 3).
    expect_op(0);
    run_reqs(4'b0001);
    check("op_count_1", 32'(op_count), 32'd1);
    expect_op(2);
    run_reqs(4'b0100);
    check("grant_idx_2", 32'(grant_idx), 32'd2);
    check("op_count_2", 32'(op_count), 32'd2);
    expect_op(3);
    expect_op(0);
    run_reqs(4'b1001);
    check("op_count_4", 32'(op_count), 32'd4);
    check("grant_idx_0", 32'(grant_idx), 32'd0);

    // Backpressure on requester 1 while requester 0 waits.
    resp_ready = 4'b1101;
    expect_op(1);
    expect_op(0);
    req_valid = 4'b0010;
    cyc = 0;
    while (!resp_valid[1] && cyc < 100) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ack;
      cyc++;
    end
    check("bp_timeout", 32'(cyc < 100), 32'd1);
    req_valid = 4'b0001;
    held_z = 32'h40800000;
    for (int i = 0; i < 10; i++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'h2);
      check("bp_resp_z", resp_z, held_z);
      check("bp_no_ack", 32'(req_ack), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    resp_ready = 4'hF;
    @(negedge clk);
    check("bp_release", 32'(resp_valid), 32'd0);
    run_reqs(4'b0001);
    check("op_count_6", 32'(op_count), 32'd6);

    // Reset while waiting on the multiplier result.
    hold_z = 1'b1;
    exp_ack_q.push_back(3);
    req_valid = 4'b1000;
    cyc = 0;
    while (!mul_z_ack && cyc < 100) begin
      @(negedge clk);
      req_valid = req_valid & ~req_ack;
      cyc++;
    end
    check("wz_timeout", 32'(cyc < 100), 32'd1);
    check("pre_rst_op_count", 32'(op_count), 32'd6);
    #2 rst = 1'b1;
    #1;
    check("async_stb_ack", 32'({mul_a_stb, mul_b_stb, mul_z_ack}), 32'd0);
    check("async_resp_valid", 32'(resp_valid), 32'd0);
    check("async_req_ack", 32'(req_ack), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_op_count", 32'(op_count), 32'd0);
    mock_flush = 1'b1;
    hold_z = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_op_count", 32'(op_count), 32'd0);

    // Round robin from reset pointer: 0,1,2,3,0,1.
    expect_op(0); expect_op(1); expect_op(2); expect_op(3); expect_op(0); expect_op(1);
    req_valid = 4'hF;
    acks = 0;
    cyc = 0;
    while (acks < 6 && cyc < 600) begin
      @(negedge clk);
      if (req_ack != 0) acks++;
      cyc++;
    end
    req_valid = '0;
    while (busy && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    check("rr_timeout", 32'(cyc < 600), 32'd1);
    check("rr_op_count", 32'(op_count), 32'd6);

    // Counter wrap (3-bit counter): 6 -> 7 -> 0.
    expect_op(2);
    run_reqs(4'b0100);
    check("op_count_7", 32'(op_count), 32'd7);
    expect_op(3);
    run_reqs(4'b1000);
    check("op_count_wrap", 32'(op_count), 32'd0);

    repeat (3) @(negedge clk);
    check("ack_q_empty", 32'(exp_ack_q.size()), 32'd0);
    check("resp_q_empty", 32'(exp_rid_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule
